frame_streamer: RTL

Drives a 32×32 8-bit image into the feature extractor's pixel stream interface and collects its completion status. The host loads a frame into an internal buffer, then issues a kick. The block then:
- pulses `start_signal`;
- streams the pixels in raster order with a programmable inter-pixel gap;
- counts `final_result_valid` beats;
- waits for `final_done_signal` with a timeout.

It sits between the host/DMA write path and the feature extractor's input port, and is the transmit end of that stream.

---
 rtl/frame_streamer.sv | 212 +++++++++++++++++++++
 1 files changed

// File: rtl/frame_streamer.sv
// frame_streamer
//   Transmit end of the pixel stream into the feature extractor. The host
//   fills an internal N-pixel frame buffer, then kicks a transfer: the block
//   pulses start_signal, streams the buffer in raster order with a
//   programmable idle gap after every pixel, counts result beats coming back
//   and waits (with timeout) for the extractor's frame-done.
//
// Ports
//   clk, rst                 clock, synchronous active-low reset
//   wr_en/wr_addr/wr_data    host buffer write port (dropped while busy)
//   kick, gap_cycles         start a transfer; gap latched at kick
//   busy, frame_done         transfer in progress / one-cycle completion
//   timeout_err, count_err   sticky status, cleared by the next kick
//   result_count             result beats this frame, saturating at 511
//   start_signal             one-cycle frame start to extractor
//   pixel_valid_in, pixel_in pixel stream to extractor
//   final_result_valid       extractor result strobe
//   final_done_signal        extractor frame completion
module frame_streamer #(
    parameter int IMG_WIDTH      = 32,
    parameter int IMG_HEIGHT     = 32,
    parameter int PIX_W          = 8,
    parameter int RESULT_COUNT   = 256,
    parameter int TIMEOUT_CYCLES = 4096,
    parameter int GAP_W          = 4,
    localparam int N             = IMG_WIDTH * IMG_HEIGHT,
    localparam int AW            = $clog2(N)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [PIX_W-1:0] wr_data,
    input  logic             kick,
    input  logic [GAP_W-1:0] gap_cycles,
    output logic             busy,
    output logic             frame_done,
    output logic             timeout_err,
    output logic             count_err,
    output logic [8:0]       result_count,
    output logic             start_signal,
    output logic             pixel_valid_in,
    output logic [PIX_W-1:0] pixel_in,
    input  logic             final_result_valid,
    input  logic             final_done_signal
);

    localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [AW:0]   N_IDX    = (AW+1)'(N);
    localparam logic [8:0]    RES_EXP  = 9'(RESULT_COUNT);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {S_IDLE, S_START, S_STREAM, S_WAIT} state_t;

    state_t state_q, state_d;

    logic [PIX_W-1:0] mem [N];
    logic [PIX_W-1:0] rd_data_q;
    logic             rd_en;
    logic [AW-1:0]    rd_addr;

    logic [AW:0]      idx_q, idx_d;          // next pixel index to read
    logic [GAP_W-1:0] gap_lat_q, gap_lat_d;
    logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;
    logic [TW-1:0]    tmo_cnt_q, tmo_cnt_d;
    logic             tmo_hit_q, tmo_hit_d;
    logic             start_q, start_d;
    logic             valid_q, valid_d;
    logic             done_q, done_d;
    logic             terr_q, terr_d;
    logic             cerr_q, cerr_d;
    logic [8:0]       rcnt_q, rcnt_d;

    // Frame buffer: writes only while idle, registered read. The read
    // register doubles as pixel_in, so it holds its value through gaps.
    always_ff @(posedge clk) begin
        if (wr_en && state_q == S_IDLE) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            rd_data_q <= '0;
        end else if (rd_en) begin
            rd_data_q <= mem[rd_addr];
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; done outside WAIT is deliberately ignored
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:   if (kick) state_d = S_START;
            S_START:  state_d = S_STREAM;
            S_STREAM: if (gap_cnt_q == '0 && idx_q == N_IDX) state_d = S_WAIT;
            S_WAIT:   if (final_done_signal || tmo_hit_q) state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // Output / datapath next values
    always_comb begin
        rd_en     = 1'b0;
        rd_addr   = '0;
        idx_d     = idx_q;
        gap_lat_d = gap_lat_q;
        gap_cnt_d = gap_cnt_q;
        tmo_cnt_d = '0;
        tmo_hit_d = 1'b0;
        start_d   = 1'b0;
        valid_d   = 1'b0;
        done_d    = 1'b0;
        terr_d    = terr_q;
        cerr_d    = cerr_q;
        rcnt_d    = rcnt_q;

        if (state_q != S_IDLE && final_result_valid && rcnt_q != '1) begin
            rcnt_d = rcnt_q + 9'd1;
        end

        unique case (state_q)
            S_IDLE: begin
                if (kick) begin
                    gap_lat_d = gap_cycles;
                    rcnt_d    = '0;
                    terr_d    = 1'b0;
                    cerr_d    = 1'b0;
                    start_d   = 1'b1;
                end
            end
            S_START: begin
                rd_en     = 1'b1;
                rd_addr   = '0;
                valid_d   = 1'b1;
                idx_d     = (AW+1)'(1);
                gap_cnt_d = gap_lat_q;
            end
            S_STREAM: begin
                if (gap_cnt_q != '0) begin
                    gap_cnt_d = gap_cnt_q - GAP_W'(1);
                end else if (idx_q != N_IDX) begin
                    // Read issued one cycle ahead of display: no bubbles at G=0
                    rd_en     = 1'b1;
                    rd_addr   = idx_q[AW-1:0];
                    valid_d   = 1'b1;
                    idx_d     = idx_q + (AW+1)'(1);
                    gap_cnt_d = gap_lat_q;
                end
            end
            S_WAIT: begin
                tmo_cnt_d = tmo_cnt_q + TW'(1);
                // Registered compare: exit follows the cycle the counter reaches
                // TIMEOUT_CYCLES-1, so the error shows TIMEOUT_CYCLES+1 after entry.
                tmo_hit_d = (tmo_cnt_q == TMO_LAST);
                if (final_done_signal || tmo_hit_q) begin
                    done_d = 1'b1;
                    terr_d = !final_done_signal;
                    cerr_d = (rcnt_d != RES_EXP);
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            idx_q     <= '0;
            gap_lat_q <= '0;
            gap_cnt_q <= '0;
            tmo_cnt_q <= '0;
            tmo_hit_q <= 1'b0;
            start_q   <= 1'b0;
            valid_q   <= 1'b0;
            done_q    <= 1'b0;
            terr_q    <= 1'b0;
            cerr_q    <= 1'b0;
            rcnt_q    <= '0;
        end else begin
            idx_q     <= idx_d;
            gap_lat_q <= gap_lat_d;
            gap_cnt_q <= gap_cnt_d;
            tmo_cnt_q <= tmo_cnt_d;
            tmo_hit_q <= tmo_hit_d;
            start_q   <= start_d;
            valid_q   <= valid_d;
            done_q    <= done_d;
            terr_q    <= terr_d;
            cerr_q    <= cerr_d;
            rcnt_q    <= rcnt_d;
        end
    end

    assign busy           = (state_q != S_IDLE);
    assign frame_done     = done_q;
    assign timeout_err    = terr_q;
    assign count_err      = cerr_q;
    assign result_count   = rcnt_q;
    assign start_signal   = start_q;
    assign pixel_valid_in = valid_q;
    assign pixel_in       = rd_data_q;

endmodule
